// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: load-type codes and writeback FSM states.
package mips_pkg;

    localparam int unsigned LDTYPE_W = 3;

    localparam logic [LDTYPE_W-1:0] LW  = 3'd0;
    localparam logic [LDTYPE_W-1:0] LH  = 3'd1;
    localparam logic [LDTYPE_W-1:0] LHU = 3'd2;
    localparam logic [LDTYPE_W-1:0] LB  = 3'd3;
    localparam logic [LDTYPE_W-1:0] LBU = 3'd4;

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } wb_state_t;

endpackage

// File: rtl/load_align.sv
// Big-endian load alignment with sign/zero extension; unknown load types pass the word through.
module load_align
    import mips_pkg::*;
(
    input  logic [LDTYPE_W-1:0] ldtype,
    input  logic [1:0]          addr_lo,
    input  logic [31:0]         rdata,
    output logic [31:0]         data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Pick the addressed byte/half (offset 0 is the most significant lane) and extend it
    always_comb begin
        sel_byte = 8'h00;
        sel_half = 16'h0000;
        data     = rdata;

        unique case (addr_lo)
            2'd0:    sel_byte = rdata[31:24];
            2'd1:    sel_byte = rdata[23:16];
            2'd2:    sel_byte = rdata[15:8];
            default: sel_byte = rdata[7:0];
        endcase

        sel_half = addr_lo[1] ? rdata[15:0] : rdata[31:16];

        case (ldtype)
            LH:      data = {{16{sel_half[15]}}, sel_half};
            LHU:     data = {16'h0000, sel_half};
            LB:      data = {{24{sel_byte[7]}}, sel_byte};
            LBU:     data = {24'h000000, sel_byte};
            LW:      data = rdata;
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: retires ALU results and aligned loads onto the register file write port.
module writeback_stage
    import mips_pkg::*;
#(
    parameter int unsigned RETIRE_W = 32
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_flush,
    input  logic [4:0]          in_rw,
    input  logic                in_regwr,
    input  logic                in_memtoreg,
    input  logic [31:0]         in_alu,
    input  logic [LDTYPE_W-1:0] in_ldtype,
    input  logic [1:0]          in_addr_lo,
    input  logic                mem_rvalid,
    input  logic [31:0]         mem_rdata,
    output logic [4:0]          RW,
    output logic [31:0]         BusW,
    output logic                RegWr,
    output logic                fwd_valid,
    output logic [4:0]          fwd_rw,
    output logic [31:0]         fwd_data,
    output logic [RETIRE_W-1:0] retired
);

    wb_state_t state;
    wb_state_t state_nxt;

    logic [4:0]          ld_rw;
    logic                ld_regwr;
    logic [LDTYPE_W-1:0] ld_type;
    logic [1:0]          ld_addr_lo;
    logic [31:0]         align_data;

    logic accept_c;
    logic alu_done_c;
    logic load_start_c;
    logic load_done_c;

    assign accept_c     = in_valid && in_ready;
    assign alu_done_c   = accept_c && !in_memtoreg;
    assign load_start_c = accept_c && in_memtoreg;
    assign load_done_c  = (state == WAIT_LOAD) && !in_flush && mem_rvalid;

    load_align u_load_align (
        .ldtype  (ld_type),
        .addr_lo (ld_addr_lo),
        .rdata   (mem_rdata),
        .data    (align_data)
    );

    // State register
    always_ff @(posedge Clk) begin
        if (Rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state: a load parks the stage until data arrives or a flush abandons it
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:      if (load_start_c) state_nxt = WAIT_LOAD;
            WAIT_LOAD: if (in_flush || mem_rvalid) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Handshake output: depends only on state and flush, never on in_valid
    always_comb begin
        in_ready = 1'b0;
        if (state == IDLE && !in_flush) in_ready = 1'b1;
    end

    // Latch destination and alignment context of an accepted load
    always_ff @(posedge Clk) begin
        if (Rst) begin
            ld_rw      <= '0;
            ld_regwr   <= 1'b0;
            ld_type    <= '0;
            ld_addr_lo <= '0;
        end else if (load_start_c) begin
            ld_rw      <= in_rw;
            ld_regwr   <= in_regwr;
            ld_type    <= in_ldtype;
            ld_addr_lo <= in_addr_lo;
        end
    end

    // WB register and retire counter; RW/BusW only move when a write is actually issued
    always_ff @(posedge Clk) begin
        if (Rst) begin
            RW      <= '0;
            BusW    <= '0;
            RegWr   <= 1'b0;
            retired <= '0;
        end else begin
            RegWr <= 1'b0;
            if (alu_done_c) begin
                retired <= retired + RETIRE_W'(1);
                if (in_regwr && in_rw != 5'd0) begin
                    RegWr <= 1'b1;
                    RW    <= in_rw;
                    BusW  <= in_alu;
                end
            end else if (load_done_c) begin
                retired <= retired + RETIRE_W'(1);
                if (ld_regwr && ld_rw != 5'd0) begin
                    RegWr <= 1'b1;
                    RW    <= ld_rw;
                    BusW  <= align_data;
                end
            end
        end
    end

    assign fwd_valid = RegWr;
    assign fwd_rw    = RW;
    assign fwd_data  = BusW;

endmodule

// File: tb/tb_writeback_stage.sv
// Randomized self-checking bench for writeback_stage against a behavioural model.
module tb_writeback_stage;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_flush;
    logic [4:0]  in_rw;
    logic        in_regwr;
    logic        in_memtoreg;
    logic [31:0] in_alu;
    logic [2:0]  in_ldtype;
    logic [1:0]  in_addr_lo;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [4:0]  RW;
    logic [31:0] BusW;
    logic        RegWr;
    logic        fwd_valid;
    logic [4:0]  fwd_rw;
    logic [31:0] fwd_data;
    logic [31:0] retired;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit          m_busy;
    logic [4:0]  p_rw;
    bit          p_regwr;
    logic [2:0]  p_lt;
    logic [1:0]  p_a;
    bit          m_wr;
    logic [4:0]  m_rw;
    logic [31:0] m_busw;
    logic [31:0] m_ret;

    always #5 Clk = ~Clk;

    writeback_stage #(.RETIRE_W(32)) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_flush    (in_flush),
        .in_rw       (in_rw),
        .in_regwr    (in_regwr),
        .in_memtoreg (in_memtoreg),
        .in_alu      (in_alu),
        .in_ldtype   (in_ldtype),
        .in_addr_lo  (in_addr_lo),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .RW          (RW),
        .BusW        (BusW),
        .RegWr       (RegWr),
        .fwd_valid   (fwd_valid),
        .fwd_rw      (fwd_rw),
        .fwd_data    (fwd_data),
        .retired     (retired)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Load result computed arithmetically from the word, offset and type
    function automatic logic [31:0] ref_align(input logic [2:0] lt, input logic [1:0] a,
                                              input logic [31:0] w);
        int unsigned b;
        int unsigned h;
        b = (w >> (8 * (3 - int'(a)))) % 256;
        h = (w >> (16 * (1 - int'(a) / 2))) % 65536;
        case (lt)
            3'd1:    return (h >= 32768) ? 32'(h) + 32'hFFFF_0000 : 32'(h);
            3'd2:    return 32'(h);
            3'd3:    return (b >= 128) ? 32'(b) + 32'hFFFF_FF00 : 32'(b);
            3'd4:    return 32'(b);
            default: return w;
        endcase
    endfunction

    // One clock: drive inputs, check in_ready, advance model, clock, check outputs
    task automatic cycle(input bit rst, input bit v, input bit fl, input logic [4:0] rw,
                         input bit rwe, input bit mtr, input logic [31:0] alu,
                         input logic [2:0] lt, input logic [1:0] a, input bit rv,
                         input logic [31:0] rd);
        bit exp_rdy;
        Rst = rst; in_valid = v; in_flush = fl; in_rw = rw; in_regwr = rwe;
        in_memtoreg = mtr; in_alu = alu; in_ldtype = lt; in_addr_lo = a;
        mem_rvalid = rv; mem_rdata = rd;
        #1;
        exp_rdy = !m_busy && !fl;
        check("in_ready", 32'(in_ready), 32'(exp_rdy));

        m_wr = 1'b0;
        if (rst) begin
            m_busy = 1'b0; m_rw = '0; m_busw = '0; m_ret = '0;
        end else if (!m_busy) begin
            if (v && exp_rdy) begin
                if (mtr) begin
                    m_busy = 1'b1; p_rw = rw; p_regwr = rwe; p_lt = lt; p_a = a;
                end else begin
                    m_ret = m_ret + 1;
                    if (rwe && rw != 0) begin
                        m_wr = 1'b1; m_rw = rw; m_busw = alu;
                    end
                end
            end
        end else if (fl) begin
            m_busy = 1'b0;
        end else if (rv) begin
            m_busy = 1'b0;
            m_ret  = m_ret + 1;
            if (p_regwr && p_rw != 0) begin
                m_wr = 1'b1; m_rw = p_rw; m_busw = ref_align(p_lt, p_a, rd);
            end
        end

        @(posedge Clk);
        #1;
        check("RegWr",     32'(RegWr),     32'(m_wr));
        check("fwd_valid", 32'(fwd_valid), 32'(m_wr));
        check("RW",        32'(RW),        32'(m_rw));
        check("BusW",      BusW,           m_busw);
        check("fwd_rw",    32'(fwd_rw),    32'(m_rw));
        check("fwd_data",  fwd_data,       m_busw);
        check("retired",   retired,        m_ret);
    endtask

    task automatic idle(input bit rv, input logic [31:0] rd, input bit fl);
        cycle(1'b0, 1'b0, fl, 5'd0, 1'b0, 1'b0, 32'd0, 3'd0, 2'd0, rv, rd);
    endtask

    task automatic do_load(input logic [2:0] lt, input logic [1:0] a, input logic [31:0] rd);
        cycle(1'b0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 32'hDEAD_BEEF, lt, a, 1'b0, 32'd0);
        idle(1'b0, 32'd0, 1'b0);
        idle(1'b1, rd, 1'b0);
    endtask

    initial begin
        m_busy = 0; p_rw = 0; p_regwr = 0; p_lt = 0; p_a = 0;
        m_wr = 0; m_rw = 0; m_busw = 0; m_ret = 0;
        Rst = 1'b1; in_valid = 0; in_flush = 0; in_rw = 0; in_regwr = 0;
        in_memtoreg = 0; in_alu = 0; in_ldtype = 0; in_addr_lo = 0;
        mem_rvalid = 0; mem_rdata = 0;
        @(posedge Clk);
        #1;
        cycle(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 3'd0, 2'd0, 1'b0, 32'd0);

        // Non-load write, then pulse drops
        cycle(1'b0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 32'h1234_5678, 3'd0, 2'd0, 1'b0, 32'd0);
        check("nl_busw_const", BusW, 32'h1234_5678);
        check("nl_ret_const", retired, 32'd1);
        idle(1'b0, 32'd0, 1'b0);

        // Byte and halfword loads
        do_load(3'd3, 2'd1, 32'h1180_2233);
        check("lb_const", BusW, 32'hFFFF_FF80);
        do_load(3'd4, 2'd1, 32'h1180_2233);
        check("lbu_const", BusW, 32'h0000_0080);
        do_load(3'd1, 2'd2, 32'h0000_9ABC);
        check("lh_const", BusW, 32'hFFFF_9ABC);
        do_load(3'd2, 2'd2, 32'h0000_9ABC);
        check("lhu_const", BusW, 32'h0000_9ABC);

        // Write to r0 is suppressed but still retires
        cycle(1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 32'hCAFE_F00D, 3'd0, 2'd0, 1'b0, 32'd0);

        // Flush beats same-cycle rvalid
        cycle(1'b0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 32'd0, 3'd0, 2'd0, 1'b0, 32'd0);
        idle(1'b1, 32'h5555_AAAA, 1'b1);
        idle(1'b0, 32'd0, 1'b0);

        // Reset during pending load abandons it
        cycle(1'b0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 32'd0, 3'd0, 2'd0, 1'b0, 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 3'd0, 2'd0, 1'b0, 32'd0);
        idle(1'b1, 32'h7777_7777, 1'b0);
        check("rst_ret_const", retired, 32'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bit r_rst, r_v, r_fl, r_rwe, r_mtr, r_rv;
            logic [4:0] r_rw;
            r_rst = ($urandom_range(0, 99) == 0);
            r_v   = ($urandom_range(0, 1) == 1);
            r_fl  = ($urandom_range(0, 7) == 0);
            r_rwe = ($urandom_range(0, 3) != 0);
            r_mtr = ($urandom_range(0, 1) == 1);
            r_rv  = ($urandom_range(0, 9) < 4);
            r_rw  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            cycle(r_rst, r_v, r_fl, r_rw, r_rwe, r_mtr, $urandom,
                  3'($urandom_range(0, 7)), 2'($urandom), r_rv, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
